// File: rtl/dmem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared definitions for the DMEM port arbiter and the CPU MEM stage:
//   - owner_e : encoding of who issued an outstanding DMEM read
//   - ACC_*   : access-type values carried on the *_we request signals
//   - cnt_width(): width needed for a counter that reaches a given limit
// ---------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic ACC_LOAD  = 1'b0;
  localparam logic ACC_STORE = 1'b1;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// ---------------------------------------------------------------------------
// dmem_starve_counter
//   Counts consecutive contentions lost by the DMA port and flags when the
//   count has reached LIMIT, at which point the arbiter lets DMA win once.
//   Ports:
//     clk          in  system clock
//     rst_n        in  asynchronous active-low reset
//     i_lost       in  both ports requested and the CPU was granted
//     i_clear      in  DMA was granted or DMA is not requesting
//     o_at_limit   out counter equals LIMIT
// ---------------------------------------------------------------------------
module dmem_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lost,
  input  logic i_clear,
  output logic o_at_limit
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_lost && (r_cnt != LIMIT_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIMIT_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares a single-port synchronous DMEM between the CPU MEM-stage port and a
//   DMA/loader port. One access per cycle, CPU priority with bounded DMA
//   starvation, 1-cycle read data steered back to the issuing port, CPU stall
//   when the CPU loses arbitration.
//   Ports:
//     clk, reset                      clock, asynchronous active-low reset
//     cpu_req/we/addr/wdata           CPU request (held while cpu_stall=1)
//     cpu_stall                       CPU request not granted this cycle
//     cpu_rvalid, cpu_rdata           CPU load response
//     dma_req/we/addr/wdata           DMA request (held until dma_gnt)
//     dma_gnt                         DMA request accepted this cycle
//     dma_rvalid, dma_rdata           DMA read response
//     mem_en/we/addr/wdata            DMEM command
//     mem_rdata                       DMEM read data, 1 cycle after a read
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WIDTH-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [WIDTH-1:0]      dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic   w_at_limit;
  logic   w_dma_gnt;
  logic   w_cpu_gnt;
  owner_e r_rd_owner;
  owner_e w_rd_owner_nxt;

  // DMA wins when it is alone, or when it has lost STARVE_LIMIT contentions
  // in a row. Grants are forced low while reset is asserted so the DMEM sees
  // no access and the CPU stalls on any held request.
  assign w_dma_gnt = reset & dma_req & (~cpu_req | w_at_limit);
  assign w_cpu_gnt = reset & cpu_req & ~w_dma_gnt;

  assign dma_gnt   = w_dma_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;

  dmem_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (reset),
    .i_lost     (dma_req & w_cpu_gnt),
    .i_clear    (w_dma_gnt | ~dma_req),
    .o_at_limit (w_at_limit)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    w_rd_owner_nxt = OWN_NONE;
    if (w_dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      if (dma_we == ACC_LOAD) w_rd_owner_nxt = OWN_DMA;
    end else if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (cpu_we == ACC_LOAD) w_rd_owner_nxt = OWN_CPU;
    end
  end

  // Tracks who owns the read data DMEM returns this cycle; reloaded every
  // edge so back-to-back reads pipeline and reset drops an in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_owner <= OWN_NONE;
    end else begin
      r_rd_owner <= w_rd_owner_nxt;
    end
  end

  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dma_rvalid = (r_rd_owner == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Self-checking bench: a behavioural DMEM answers the DUT's mem_* port; a
//   reference memory plus arbitration model predicts grants and read data,
//   and predicted read responses wait in a scoreboard queue for the next cycle.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int WIDTH        = 12;
  localparam int DATA_WIDTH   = 16;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    owner_e                own;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cpu_req, cpu_we, dma_req, dma_we;
  logic [WIDTH-1:0]      cpu_addr, dma_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, dma_wdata;
  logic                  cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata, dma_rdata;
  logic                  mem_en, mem_we;
  logic [WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata = '0;

  logic [DATA_WIDTH-1:0] tb_mem  [0:(1<<WIDTH)-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] ref_mem [0:(1<<WIDTH)-1] = '{default: '0};

  exp_t sb[$];
  int   m_starve = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .WIDTH        (WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Single-port synchronous DMEM with 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= tb_mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive requests, compare last cycle's read response and this
  // cycle's grant/mux against the model, then advance the model past the edge.
  task automatic cycle(input logic c_req, input logic c_we,
                       input logic [WIDTH-1:0] c_addr, input logic [DATA_WIDTH-1:0] c_wd,
                       input logic d_req, input logic d_we,
                       input logic [WIDTH-1:0] d_addr, input logic [DATA_WIDTH-1:0] d_wd);
    exp_t e;
    logic e_dma, e_cpu;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.own  = OWN_NONE;
      e.data = '0;
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e.own == OWN_CPU));
    check("dma_rvalid", 32'(dma_rvalid), 32'(e.own == OWN_DMA));
    if (e.own == OWN_CPU) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
    if (e.own == OWN_DMA) check("dma_rdata", 32'(dma_rdata), 32'(e.data));

    e_dma = d_req & (~c_req | (m_starve == STARVE_LIMIT));
    e_cpu = c_req & ~e_dma;
    check("dma_gnt",   32'(dma_gnt),   32'(e_dma));
    check("cpu_stall", 32'(cpu_stall), 32'(c_req & ~e_cpu));
    check("mem_en",    32'(mem_en),    32'(e_dma | e_cpu));
    if (e_dma) begin
      check("mem_we_dma",   32'(mem_we),   32'(d_we));
      check("mem_addr_dma", 32'(mem_addr), 32'(d_addr));
      if (d_we) check("mem_wdata_dma", 32'(mem_wdata), 32'(d_wd));
    end else if (e_cpu) begin
      check("mem_we_cpu",   32'(mem_we),   32'(c_we));
      check("mem_addr_cpu", 32'(mem_addr), 32'(c_addr));
      if (c_we) check("mem_wdata_cpu", 32'(mem_wdata), 32'(c_wd));
    end

    e.own  = OWN_NONE;
    e.data = '0;
    if (e_dma && !d_we) begin
      e.own = OWN_DMA; e.data = ref_mem[d_addr];
    end else if (e_cpu && !c_we) begin
      e.own = OWN_CPU; e.data = ref_mem[c_addr];
    end
    sb.push_back(e);
    if (e_dma && d_we) ref_mem[d_addr] = d_wd;
    if (e_cpu && c_we) ref_mem[c_addr] = c_wd;

    if (e_dma || !d_req)                              m_starve = 0;
    else if (c_req && m_starve < STARVE_LIMIT)        m_starve++;

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, ACC_LOAD, '0, '0, 1'b0, ACC_LOAD, '0, '0);
  endtask

  // Assert reset for one cycle with the CPU requesting; model state is flushed.
  task automatic reset_pulse();
    reset   = 1'b0;
    cpu_req = 1'b1; cpu_we = ACC_LOAD; cpu_addr = 12'd3;
    dma_req = 1'b0;
    sb.delete();
    m_starve = 0;
    @(negedge clk);
    check("rst_mem_en",     32'(mem_en),     32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    check("rst_cpu_stall",  32'(cpu_stall),  32'd1);
    check("rst_dma_gnt",    32'(dma_gnt),    32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse();

    // First cycle after release: CPU load arbitrates normally.
    cycle(1'b1, ACC_LOAD, 12'd0, '0, 1'b0, ACC_LOAD, '0, '0);

    // CPU store then load of the same word.
    cycle(1'b1, ACC_STORE, 12'd3, 16'h1234, 1'b0, ACC_LOAD, '0, '0);
    cycle(1'b1, ACC_LOAD,  12'd3, '0,       1'b0, ACC_LOAD, '0, '0);
    idle();
    check("store_load_mem", 32'(tb_mem[3]), 32'h1234);

    // Interleaved CPU/DMA reads return to the right port in order.
    cycle(1'b1, ACC_STORE, 12'd1, 16'hAAAA, 1'b0, ACC_LOAD,  '0,    '0);
    cycle(1'b0, ACC_LOAD,  '0,    '0,       1'b1, ACC_STORE, 12'd2, 16'h5555);
    cycle(1'b1, ACC_LOAD,  12'd1, '0,       1'b0, ACC_LOAD,  '0,    '0);
    cycle(1'b0, ACC_LOAD,  '0,    '0,       1'b1, ACC_LOAD,  12'd2, '0);
    idle();

    // Continuous contention: CPU wins STARVE_LIMIT cycles, then DMA once.
    for (int i = 0; i < 3 * (STARVE_LIMIT + 1); i++) begin
      cycle(1'b1, ACC_LOAD, 12'd3, '0, 1'b1, ACC_LOAD, 12'd1, '0);
      check("contend_pattern", 32'(sb[sb.size()-1].own),
            32'((i % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? OWN_DMA : OWN_CPU));
    end
    idle();

    // DMA-only write burst, then read it back pipelined.
    for (int i = 0; i < 16; i++)
      cycle(1'b0, ACC_LOAD, '0, '0, 1'b1, ACC_STORE, 12'(i), 16'(i));
    idle();
    for (int i = 0; i < 16; i++) check("burst_mem", 32'(tb_mem[i]), 32'(i));
    for (int i = 0; i < 16; i++)
      cycle(1'b0, ACC_LOAD, '0, '0, 1'b1, ACC_LOAD, 12'(i), '0);
    idle();

    // Random mix over a small address window.
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 15)), 16'($urandom));
    idle();

    // Reset right after a granted CPU load with the starve counter at limit:
    // the load response is dropped and DMA must again wait STARVE_LIMIT cycles.
    for (int i = 0; i < STARVE_LIMIT; i++)
      cycle(1'b1, ACC_LOAD, 12'd3, '0, 1'b1, ACC_LOAD, 12'd1, '0);
    reset_pulse();
    for (int i = 0; i < STARVE_LIMIT + 2; i++)
      cycle(1'b1, ACC_LOAD, 12'd3, '0, 1'b1, ACC_LOAD, 12'd1, '0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
